bsg_manycore_barrier_ctrl: RTL and testbench
============================================

// Module: bsg_manycore_barrier_ctrl
// PURPOSE
//  Per-tile controller that configures and sequences the tile's hardware barrier node (bsg_barrier).
//  Holds the barrier src mask / dest select written by the core and drives them to the barrier node.
//  Turns a core "join" request into a sense-toggle on the P barrier port, then waits for the network's
//  sense to match and returns a single-cycle done. Sits between the hetero socket and bsg_barrier.
// PARAMETERS
//  barrier_dirs_p      7   barrier node ports (P,W,E,N,S,RW,RE); width of src mask
//  barrier_lg_dirs_lp  -   localparam, `BSG_SAFE_CLOG2(barrier_dirs_p+1); width of dest select
//  count_width_p       16  width of completed-barrier counter
//  timeout_width_p     20  width of wait timer (used only with the optional feature)
// PORTS
//  clk_i              in   1                  clock
//  reset_n_i          in   1                  asynchronous reset, active-low
//  cfg_v_i            in   1                  config write valid
//  cfg_data_i         in   barrier_lg_dirs_lp+barrier_dirs_p  {dest, src_mask}
//  cfg_ready_o        out  1                  config write accepted when v&ready
//  join_v_i           in   1                  core requests barrier join
//  join_ready_o       out  1                  join accepted when v&ready
//  done_o             out  1                  one-cycle pulse: barrier complete
//  barrier_data_i     in   1                  P-port output of barrier node (network sense)
//  barrier_data_o     out  1                  P-port input to barrier node (local sense)
//  barrier_src_r_o    out  barrier_dirs_p     src mask to barrier node
//  barrier_dest_r_o   out  barrier_lg_dirs_lp dest select to barrier node
//  barrier_count_o    out  count_width_p      number of completed barriers
//  timeout_o          out  1                  sticky wait-timeout flag (0 without feature)
// BEHAVIOUR
//  Reset (async, reset_n_i=0): state=IDLE; all outputs 0; sense_r=0; cfg_valid_r=0; counter=0.
//   Reset mid-WAIT abandons the barrier; sense returns to 0.
//  States: IDLE, WAIT, DONE.
//  IDLE: cfg_ready_o=1. join_ready_o = cfg_valid_r & ~cfg_v_i (config write wins a same-cycle tie).
//   cfg accept: src/dest regs <= cfg_data_i, cfg_valid_r<=1 next edge; stay IDLE.
//   join accept: sense_r <= ~sense_r, -> WAIT.
//  WAIT: cfg_ready_o=0, join_ready_o=0. If barrier_data_i == sense_r -> DONE.
//  DONE: done_o=1 for exactly this cycle; barrier_count_o += 1 (wraps mod 2^count_width_p); -> IDLE.
//  barrier_data_o = sense_r (registered, no comb path from any input).
//  Latency: join accepted in cycle N -> earliest done_o in cycle N+2 (sense already matched in N+1).
//  Config is frozen while not IDLE; src/dest outputs never change during a barrier.
//  join before any config: join_ready_o=0, request stalls indefinitely.
// CONFIGURATION
//  BSG_MANYCORE_BARRIER_TIMEOUT_EN defined: timer clears on join accept, increments each WAIT cycle,
//   saturates at all-ones; on reaching all-ones timeout_o<=1, sticky until next join accept or reset.
//   Timeout is diagnostic only; FSM keeps waiting. Without macro: no timer, timeout_o tied 0.
// STRUCTURE
//  bsg_manycore_pkg: bsg_manycore_barrier_ctrl_state_e {IDLE,WAIT,DONE};
//   bsg_manycore_barrier_cfg_s packed {dest, src_mask} parameterised via `declare macro.
//  Sub-module: bsg_manycore_barrier_timer (saturating counter + sticky flag), instantiated only under macro.
// TESTING
//  1 reset: reset_n_i=0 mid-WAIT -> state IDLE, barrier_data_o=0, src/dest=0, count=0 immediately.
//  2 config: cfg_data_i={dest=3,src=7'b0000110} -> barrier_src_r_o=0x06, dest_r=3 next cycle, join_ready_o=1.
//  3 join, loopback sense at N+1 -> barrier_data_o=1 at N+1, done_o at N+2 only, count=1; second join -> data_o=0, count=2.
//  4 tie: cfg_v_i=join_v_i=1 in IDLE -> cfg taken, join_ready_o=0 that cycle, join taken next cycle.
//  5 WAIT with barrier_data_i held off 100 cycles -> cfg_ready_o=0 throughout, no done_o; release -> done 1 cycle later.
//  6 with macro, timeout_width_p=4: hold WAIT 15 cycles -> timeout_o=1 sticky; next join accept -> 0; count wraps at 2^16.

Source files
------------

// File: rtl/bsg_manycore_pkg.sv
// Shared types for the manycore tile barrier controller.
//
// Contents:
//   bsg_manycore_barrier_ctrl_state_e  controller states IDLE / WAIT / DONE
//   safe_clog2()                       clog2 that never returns less than 1
//   `BSG_MANYCORE_BARRIER_CFG_S_DECLARE(dirs, lg_dirs)
//       declares bsg_manycore_barrier_cfg_s, packed {dest, src_mask}, sized
//       by the caller. A package cannot take parameters, so the struct is
//       declared inside the user module through this macro.
//
// Optional feature macro used by the controller: BSG_MANYCORE_BARRIER_TIMEOUT_EN.

`ifndef BSG_MANYCORE_PKG_SV
`define BSG_MANYCORE_PKG_SV

`define BSG_MANYCORE_BARRIER_CFG_S_DECLARE(dirs_mp, lg_dirs_mp) \
    typedef struct packed { \
        logic [lg_dirs_mp-1:0] dest; \
        logic [dirs_mp-1:0]    src_mask; \
    } bsg_manycore_barrier_cfg_s;

package bsg_manycore_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } bsg_manycore_barrier_ctrl_state_e;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

`endif

// File: rtl/bsg_manycore_barrier_timer.sv
// Saturating wait timer with a sticky timeout flag.
//
// Only built when BSG_MANYCORE_BARRIER_TIMEOUT_EN is defined.
//
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous reset, active-low
//   clear_i    clear counter and flag (new barrier joined)
//   tick_i     count one waiting cycle
//   timeout_o  set when the counter reaches all-ones; held until clear/reset

`ifdef BSG_MANYCORE_BARRIER_TIMEOUT_EN
module bsg_manycore_barrier_timer #(
    parameter int width_p = 20
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clear_i,
    input  logic tick_i,
    output logic timeout_o
);

    logic [width_p-1:0] count_r;
    logic               at_max;
    logic               one_below_max;

    assign at_max        = &count_r;
    assign one_below_max = (count_r == {{(width_p-1){1'b1}}, 1'b0});

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r   <= '0;
            timeout_o <= 1'b0;
        end else if (clear_i) begin
            count_r   <= '0;
            timeout_o <= 1'b0;
        end else if (tick_i && !at_max) begin
            count_r <= count_r + 1'b1;
            // Flag rises on the same edge the counter lands on all-ones.
            if (one_below_max) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/bsg_manycore_barrier_ctrl.sv
// Per-tile barrier controller: holds the src mask / dest select for the
// tile's barrier node, turns a core join into a sense toggle on the P port,
// waits for the network sense to match and pulses done for one cycle.
//
// Optional feature: BSG_MANYCORE_BARRIER_TIMEOUT_EN adds a diagnostic wait
// timer driving timeout_o; without it timeout_o is tied 0.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high; ready never depends on the same-channel valid, and valid
// may be raised or dropped freely by the core.
//
// Ports:
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   cfg_v_i/cfg_data_i/cfg_ready_o   config write {dest, src_mask}
//   join_v_i/join_ready_o            barrier join request
//   done_o             one-cycle pulse when the barrier completes
//   barrier_data_i     network sense from the barrier node P port
//   barrier_data_o     local sense to the barrier node P port
//   barrier_src_r_o    src mask to barrier node
//   barrier_dest_r_o   dest select to barrier node
//   barrier_count_o    completed-barrier count (wraps)
//   timeout_o          sticky wait-timeout flag
//   state_o            current controller state (debug)

module bsg_manycore_barrier_ctrl
    import bsg_manycore_pkg::*;
#(
    parameter int barrier_dirs_p  = 7,
    parameter int count_width_p   = 16,
    parameter int timeout_width_p = 20,
    localparam int barrier_lg_dirs_lp = safe_clog2(barrier_dirs_p + 1)
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic                                       cfg_v_i,
    input  logic [barrier_lg_dirs_lp+barrier_dirs_p-1:0] cfg_data_i,
    output logic                                       cfg_ready_o,
    input  logic                                       join_v_i,
    output logic                                       join_ready_o,
    output logic                                       done_o,
    input  logic                                       barrier_data_i,
    output logic                                       barrier_data_o,
    output logic [barrier_dirs_p-1:0]                  barrier_src_r_o,
    output logic [barrier_lg_dirs_lp-1:0]              barrier_dest_r_o,
    output logic [count_width_p-1:0]                   barrier_count_o,
    output logic                                       timeout_o,
    output bsg_manycore_barrier_ctrl_state_e           state_o
);

    `BSG_MANYCORE_BARRIER_CFG_S_DECLARE(barrier_dirs_p, barrier_lg_dirs_lp)

    bsg_manycore_barrier_ctrl_state_e state_r, state_next;
    bsg_manycore_barrier_cfg_s        cfg_in, cfg_r;

    logic                     idle_r;
    logic                     done_r;
    logic                     sense_r;
    logic                     cfg_valid_r;
    logic [count_width_p-1:0] count_r;
    logic                     cfg_accept;
    logic                     join_accept;

    assign cfg_in = cfg_data_i;

    // idle_r is a registered copy of "state is IDLE" that is 0 while in
    // reset, so both readies are low during reset and come up one edge
    // after release.
    assign cfg_ready_o  = idle_r;
    // A config write in the same cycle takes priority over a join.
    assign join_ready_o = idle_r & cfg_valid_r & ~cfg_v_i;

    assign cfg_accept  = cfg_v_i & cfg_ready_o;
    assign join_accept = join_v_i & join_ready_o;

    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE:    if (join_accept) state_next = WAIT;
            WAIT:    if (barrier_data_i == sense_r) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= IDLE;
            idle_r      <= 1'b0;
            done_r      <= 1'b0;
            sense_r     <= 1'b0;
            cfg_valid_r <= 1'b0;
            cfg_r       <= '0;
            count_r     <= '0;
        end else begin
            state_r <= state_next;
            idle_r  <= (state_next == IDLE);
            done_r  <= (state_next == DONE);
            if (cfg_accept) begin
                cfg_r       <= cfg_in;
                cfg_valid_r <= 1'b1;
            end
            if (join_accept) begin
                sense_r <= ~sense_r;
            end
            if (state_r == DONE) begin
                count_r <= count_r + 1'b1;
            end
        end
    end

    assign done_o           = done_r;
    assign barrier_data_o   = sense_r;
    assign barrier_src_r_o  = cfg_r.src_mask;
    assign barrier_dest_r_o = cfg_r.dest;
    assign barrier_count_o  = count_r;
    assign state_o          = state_r;

`ifdef BSG_MANYCORE_BARRIER_TIMEOUT_EN
    bsg_manycore_barrier_timer #(
        .width_p(timeout_width_p)
    ) timer (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clear_i  (join_accept),
        .tick_i   (state_r == WAIT),
        .timeout_o(timeout_o)
    );
`else
    localparam int unused_timeout_width_lp = timeout_width_p;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_manycore_barrier_ctrl.sv
module tb_bsg_manycore_barrier_ctrl;
    import bsg_manycore_pkg::*;

    localparam int DIRS = 7;
    localparam int LG   = 3;
    localparam int CW   = 5;
    localparam int TW   = 4;
    localparam int TO_LIMIT = (1 << TW) - 1;
`ifdef BSG_MANYCORE_BARRIER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic                 cfg_v = 1'b0;
    logic [LG+DIRS-1:0]   cfg_data = '0;
    logic                 cfg_ready;
    logic                 join_v = 1'b0;
    logic                 join_ready;
    logic                 done;
    logic                 barrier_in = 1'b0;
    logic                 barrier_out;
    logic [DIRS-1:0]      src_r;
    logic [LG-1:0]        dest_r;
    logic [CW-1:0]        count;
    logic                 timeout;
    bsg_manycore_barrier_ctrl_state_e state;

    bsg_manycore_barrier_ctrl #(
        .barrier_dirs_p (DIRS),
        .count_width_p  (CW),
        .timeout_width_p(TW)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .cfg_v_i         (cfg_v),
        .cfg_data_i      (cfg_data),
        .cfg_ready_o     (cfg_ready),
        .join_v_i        (join_v),
        .join_ready_o    (join_ready),
        .done_o          (done),
        .barrier_data_i  (barrier_in),
        .barrier_data_o  (barrier_out),
        .barrier_src_r_o (src_r),
        .barrier_dest_r_o(dest_r),
        .barrier_count_o (count),
        .timeout_o       (timeout),
        .state_o         (state)
    );

    // ---------------- reference model ----------------
    logic [DIRS-1:0] m_src;
    logic [LG-1:0]   m_dest;
    bit              m_cfg_valid;
    bit              m_sense;      // parity of accepted joins
    int              m_count;      // completed barriers, mod 2^CW
    int              m_wait;       // WAIT cycles in current/last barrier
    logic [CW-1:0]   exp_q[$];     // expected count after each pending barrier

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_timeout();
        return TO_EN && (m_wait >= TO_LIMIT);
    endfunction

    function automatic logic [31:0] idle_code();
        bsg_manycore_barrier_ctrl_state_e s = IDLE;
        return 32'(s);
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a falling edge.
    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state), idle_code());
        check({tag, "_data_o"}, 32'(barrier_out), 0);
        check({tag, "_src"}, 32'(src_r), 0);
        check({tag, "_dest"}, 32'(dest_r), 0);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_cfg_ready"}, 32'(cfg_ready), 0);
        check({tag, "_join_ready"}, 32'(join_ready), 0);
        check({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    task automatic model_reset();
        m_src = '0; m_dest = '0; m_cfg_valid = 0; m_sense = 0;
        m_count = 0; m_wait = 0; exp_q.delete();
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_cfg_ready", 32'(cfg_ready), 1);
    endtask

    task automatic cfg_write(input logic [LG-1:0] d, input logic [DIRS-1:0] s);
        cfg_v = 1'b1;
        cfg_data = {d, s};
        #1;
        check("cfg_ready", 32'(cfg_ready), 1);
        check("join_ready_cfg_tie", 32'(join_ready), 0);
        @(negedge clk);
        cfg_v = 1'b0;
        m_src = s; m_dest = d; m_cfg_valid = 1;
        check("cfg_src", 32'(src_r), 32'(m_src));
        check("cfg_dest", 32'(dest_r), 32'(m_dest));
    endtask

    // Join, hold the network sense off for 'delay' cycles, then match it.
    task automatic join_barrier(input int delay);
        join_v = 1'b1;
        #1;
        check("join_ready", 32'(join_ready), 32'(m_cfg_valid));
        check("timeout_before_join", 32'(timeout), 32'(exp_timeout()));
        @(negedge clk);
        join_v = 1'b0;
        m_sense = ~m_sense;
        m_wait = 0;
        exp_q.push_back(CW'(m_count + 1));
        check("wait_data_o", 32'(barrier_out), 32'(m_sense));
        check("wait_done", 32'(done), 0);
        for (int i = 0; i < delay; i++) begin
            barrier_in = ~m_sense;
            cfg_v = 1'($urandom_range(0, 1));
            cfg_data = (LG+DIRS)'($urandom);
            join_v = 1'($urandom_range(0, 1));
            #1;
            check("wait_cfg_ready", 32'(cfg_ready), 0);
            check("wait_join_ready", 32'(join_ready), 0);
            check("wait_timeout", 32'(timeout), 32'(exp_timeout()));
            @(negedge clk);
            m_wait++;
            check("wait_no_done", 32'(done), 0);
            check("wait_src_frozen", 32'(src_r), 32'(m_src));
            check("wait_dest_frozen", 32'(dest_r), 32'(m_dest));
        end
        cfg_v = 1'b0;
        join_v = 1'b0;
        barrier_in = m_sense;
        @(negedge clk);
        m_wait++;
        check("done_pulse", 32'(done), 1);
        check("done_cfg_ready", 32'(cfg_ready), 0);
        check("done_timeout", 32'(timeout), 32'(exp_timeout()));
        m_count = int'(exp_q.pop_front());
        @(negedge clk);
        check("done_single", 32'(done), 0);
        check("count", 32'(count), 32'(m_count));
        check("idle_cfg_ready", 32'(cfg_ready), 1);
        check("idle_data_o", 32'(barrier_out), 32'(m_sense));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1;
        model_reset();
        check_reset_outputs("reset0");
        release_reset();

        // Join before any config stalls.
        join_v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("nocfg_join_ready", 32'(join_ready), 0);
            @(negedge clk);
            check("nocfg_state", 32'(state), idle_code());
            check("nocfg_data_o", 32'(barrier_out), 0);
        end
        join_v = 1'b0;

        // Directed config and two back-to-back barriers with loopback sense.
        cfg_write(3'd3, 7'b0000110);
        check("dir_src", 32'(src_r), 32'h06);
        check("dir_dest", 32'(dest_r), 32'd3);
        join_barrier(0);
        check("dir_count1", 32'(count), 1);
        check("dir_sense1", 32'(barrier_out), 1);
        join_barrier(0);
        check("dir_count2", 32'(count), 2);
        check("dir_sense2", 32'(barrier_out), 0);

        // Same-cycle cfg and join: cfg wins, join goes next cycle.
        cfg_v = 1'b1;
        join_v = 1'b1;
        cfg_data = {3'd5, 7'b1010001};
        #1;
        check("tie_join_ready", 32'(join_ready), 0);
        check("tie_cfg_ready", 32'(cfg_ready), 1);
        @(negedge clk);
        cfg_v = 1'b0;
        m_src = 7'b1010001; m_dest = 3'd5; m_cfg_valid = 1;
        check("tie_src", 32'(src_r), 32'(m_src));
        check("tie_state", 32'(state), idle_code());
        join_barrier(1);

        // Long wait with the network held off.
        join_barrier(100);
        // Short follow-up clears any sticky timeout on accept.
        join_barrier(2);

        // Randomized config/join traffic; enough barriers to wrap the counter.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                cfg_write(LG'($urandom), DIRS'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("rand_idle_done", 32'(done), 0);
            end
            join_barrier($urandom_range(0, 20));
        end

        // Reset in the middle of a barrier abandons it.
        join_v = 1'b1;
        @(negedge clk);
        join_v = 1'b0;
        barrier_in = ~barrier_out;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("reset_mid_wait");
        barrier_in = 1'b0;
        release_reset();
        cfg_write(3'd1, 7'b1111111);
        join_barrier(3);
        check("post_reset_count", 32'(count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
